deser_packed_if: RTL and testbench

// - Parametrised serial-to-parallel deserialiser: accepts W_LANE-bit beats, assembles W_WORD-bit words in
//   a packed array held in an internal interface instance, presents complete words on a valid/ready output.
// - Generalises the one-bit-per-clock packed fill: configurable beat width, bit order, flush, handshaking
//   and a wrap-safe beat index (no unbounded counter).
// - Sits between a narrow serial source and word-wide consumers in the interface/packed-array testcases.

---
 rtl/deser_pkg.sv | 14 +
 rtl/deser_word_if.sv | 6 +
 rtl/deser_out_reg.sv | 35 +++
 rtl/deser_packed_if.sv | 88 ++++++++
 tb/tb_deser_packed_if.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the packed-array deserialiser.
package deser_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } order_e;

  // Bit offset inside the assembled word where beat k lands.
  function automatic int beat_lsb(input int k, input int beats, input int w_lane, input int msb_first);
    return (msb_first != 0) ? (beats - 1 - k) * w_lane : k * w_lane;
  endfunction

endpackage

// File: rtl/deser_word_if.sv
// Holds the partially assembled word as a packed array shared by reference.
interface deser_word_if #(
  parameter int W_WORD = 8
);
  logic [W_WORD-1:0] word;
endinterface

// File: rtl/deser_out_reg.sv
// Single-entry output holding register: loads completed words, drains on i_ready.
module deser_out_reg #(
  parameter int W_WORD = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [W_WORD-1:0] i_word,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [W_WORD-1:0] o_a,
  output logic              full_next_blocked
);

  logic              valid_reg;
  logic [W_WORD-1:0] word_reg;

  // A load in the same cycle as a drain keeps valid high with the new word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_reg <= 1'b0;
      word_reg  <= '0;
    end else if (i_load) begin
      valid_reg <= 1'b1;
      word_reg  <= i_word;
    end else if (valid_reg && i_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_valid           = valid_reg;
  assign o_a               = word_reg;
  assign full_next_blocked = valid_reg && !i_ready;

endmodule

// File: rtl/deser_packed_if.sv
// Serial-to-parallel deserialiser: W_LANE-bit beats into W_WORD-bit words
// assembled in an interface-held packed array, emitted on a valid/ready port.
module deser_packed_if #(
  parameter int W_WORD = 8,
  parameter int W_LANE = 1,
  parameter int MSB_FIRST = 0,
  localparam int BEATS = W_WORD / W_LANE,
  localparam int W_IDX = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [W_LANE-1:0] i_a,
  output logic              o_ready,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [W_WORD-1:0] o_a,
  input  logic              i_ready,
  output logic [W_IDX-1:0]  o_idx
);
  import deser_pkg::*;

  localparam order_e ORDER = (MSB_FIRST == 1) ? deser_pkg::MSB_FIRST : LSB_FIRST;
  localparam int ORDER_MSB = (ORDER == deser_pkg::MSB_FIRST) ? 1 : 0;
  localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(BEATS - 1);

  generate
    if (W_LANE < 1 || W_LANE > W_WORD) begin : g_bad_lane
      $error("deser_packed_if: W_LANE must be in 1..W_WORD");
    end
    if ((W_WORD % W_LANE) != 0) begin : g_bad_ratio
      $error("deser_packed_if: W_WORD must be a multiple of W_LANE");
    end
    if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_order
      $error("deser_packed_if: MSB_FIRST must be 0 or 1");
    end
  endgenerate

  deser_word_if #(.W_WORD(W_WORD)) acc_if ();

  logic [W_IDX-1:0]  idx_reg;
  logic [W_WORD-1:0] word_merged;
  logic              full_next_blocked;
  logic              last_beat;
  logic              accept;
  logic              word_done;

  // Only the completing beat has to wait for the output register to free up.
  assign last_beat = (idx_reg == LAST_IDX);
  assign o_ready   = !(last_beat && full_next_blocked);
  assign accept    = i_valid && o_ready && !i_flush;
  assign word_done = accept && last_beat;
  assign o_idx     = idx_reg;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
      localparam int SLOT_LSB = beat_lsb(gi, BEATS, W_LANE, ORDER_MSB);
      assign word_merged[SLOT_LSB +: W_LANE] =
        (accept && (idx_reg == W_IDX'(gi))) ? i_a : acc_if.word[SLOT_LSB +: W_LANE];
    end
  endgenerate

  // Accumulator is cleared on completion so unwritten slots of the next word read as zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_reg     <= '0;
      acc_if.word <= '0;
    end else if (i_flush) begin
      idx_reg     <= '0;
      acc_if.word <= '0;
    end else if (accept) begin
      idx_reg     <= last_beat ? '0 : idx_reg + W_IDX'(1);
      acc_if.word <= last_beat ? '0 : word_merged;
    end
  end

  deser_out_reg #(.W_WORD(W_WORD)) u_out (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_load            (word_done),
    .i_word            (word_merged),
    .i_ready           (i_ready),
    .o_valid           (o_valid),
    .o_a               (o_a),
    .full_next_blocked (full_next_blocked)
  );

endmodule

// File: tb/tb_deser_packed_if.sv
// Bench for deser_packed_if: 1-bit LSB-first and 4-bit MSB-first instances.
`timescale 1ns/1ps
module tb_deser_packed_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, f0, r0, ordy0, ov0;
  logic [0:0] a0;
  logic [7:0] oa0;
  logic [2:0] oidx0;
  logic       v1, f1, r1, ordy1, ov1;
  logic [3:0] a1;
  logic [7:0] oa1;
  logic [0:0] oidx1;

  deser_packed_if dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(v0), .i_a(a0), .o_ready(ordy0), .i_flush(f0),
    .o_valid(ov0), .o_a(oa0), .i_ready(r0), .o_idx(oidx0)
  );

  deser_packed_if #(.W_WORD(8), .W_LANE(4), .MSB_FIRST(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .i_a(a1), .o_ready(ordy1), .i_flush(f1),
    .o_valid(ov1), .o_a(oa1), .i_ready(r1), .o_idx(oidx1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: beats collected so far, partial word, pending output word.
  int         mc[2];
  logic [7:0] mp[2];
  logic [7:0] mw[2];
  logic       mv[2];
  logic       er[2];
  logic       sr[2];
  int         tv[2], ta[2], tf[2], tr[2];

  function automatic void model_update(input int k);
    int   b, l, off;
    logic acc, drain, done;
    b = (k == 1) ? 2 : 8;
    l = (k == 1) ? 4 : 1;
    if (rst) begin
      mc[k] = 0; mp[k] = '0; mw[k] = '0; mv[k] = 1'b0;
      return;
    end
    acc   = (tv[k] != 0) && er[k] && (tf[k] == 0);
    drain = mv[k] && (tr[k] != 0);
    done  = 1'b0;
    if (tf[k] != 0) begin
      mc[k] = 0; mp[k] = '0;
    end else if (acc) begin
      off   = (k == 1) ? (b - 1 - mc[k]) * l : mc[k] * l;
      mp[k] = mp[k] | 8'((ta[k] & ((1 << l) - 1)) << off);
      mc[k] = mc[k] + 1;
      if (mc[k] == b) begin
        mw[k] = mp[k]; mv[k] = 1'b1; mp[k] = '0; mc[k] = 0; done = 1'b1;
        $display("[%0t] dut%0d word %02h", $time, k, mw[k]);
      end
    end
    if (!done && drain) mv[k] = 1'b0;
  endfunction

  task automatic tick();
    v0 = (tv[0] != 0); f0 = (tf[0] != 0); r0 = (tr[0] != 0);
    a0 = (tv[0] != 0) ? 1'(ta[0]) : 1'bx;
    v1 = (tv[1] != 0); f1 = (tf[1] != 0); r1 = (tr[1] != 0);
    a1 = (tv[1] != 0) ? 4'(ta[1]) : 4'bx;
    #1;
    for (int k = 0; k < 2; k++)
      er[k] = !((mc[k] == ((k == 1) ? 1 : 7)) && mv[k] && (tr[k] == 0));
    sr[0] = ordy0;
    sr[1] = ordy1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    @(negedge clk);
  endtask

  task automatic step(input int s, input int v, input int a, input int f, input int r);
    for (int k = 0; k < 2; k++) begin
      tv[k] = (k == s) ? v : 0;
      ta[k] = (k == s) ? a : 0;
      tf[k] = (k == s) ? f : 0;
      tr[k] = (k == s) ? r : 1;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    rst = 1'b0;
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ov0); end
    n_cmp++; if (oa0 !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", oa0); end
    n_cmp++; if (oidx0 !== 3'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", oidx0); end
    n_cmp++; if (ov1 !== 1'b0 || oidx1 !== 1'b0) begin n_bad++; $display("FAIL reset_dut1: got v=%b idx=%0d want 0/0", ov1, oidx1); end
    step(0, 0, 0, 0, 1);
    n_cmp++; if (sr[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", sr[0]); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, int'(bits[k]), 0, 1);
      n_cmp++; if (oidx0 !== 3'((k + 1) % 8)) begin n_bad++; $display("FAIL lsb_idx%0d: got %0d want %0d", k, oidx0, (k + 1) % 8); end
      if (k < 7) begin
        n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL lsb_early_valid%0d: got %b want 0", k, ov0); end
      end
    end
    n_cmp++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL lsb_valid: got %b want 1", ov0); end
    n_cmp++; if (oa0 !== 8'h4D) begin n_bad++; $display("FAIL lsb_word: got %h want 4d", oa0); end
    step(0, 0, 0, 0, 1);
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL lsb_one_cycle: got %b want 0", ov0); end
  endtask

  task automatic test_msb_lane4();
    step(1, 1, 'hA, 0, 1);
    n_cmp++; if (ov1 !== 1'b0 || oidx1 !== 1'b1) begin n_bad++; $display("FAIL msb_beat0: got v=%b idx=%0d want 0/1", ov1, oidx1); end
    step(1, 1, 'h5, 0, 1);
    n_cmp++; if (ov1 !== 1'b1 || oa1 !== 8'hA5) begin n_bad++; $display("FAIL msb_word1: got v=%b %h want 1/a5", ov1, oa1); end
    step(1, 1, 'h3, 0, 0);
    n_cmp++; if (ov1 !== 1'b1 || oa1 !== 8'hA5 || oidx1 !== 1'b1) begin n_bad++; $display("FAIL msb_hold: got v=%b %h idx=%0d want 1/a5/1", ov1, oa1, oidx1); end
    step(1, 1, 'hC, 0, 1);
    n_cmp++; if (ov1 !== 1'b1 || oa1 !== 8'h3C) begin n_bad++; $display("FAIL msb_word2: got v=%b %h want 1/3c", ov1, oa1); end
    step(1, 0, 0, 0, 1);
    n_cmp++; if (ov1 !== 1'b0) begin n_bad++; $display("FAIL msb_drain: got %b want 0", ov1); end
  endtask

  task automatic test_backpressure();
    logic [15:0] val;
    val = 16'($urandom);
    for (int k = 0; k < 15; k++) step(0, 1, int'(val[k]), 0, 0);
    n_cmp++; if (ov0 !== 1'b1 || oa0 !== val[7:0]) begin n_bad++; $display("FAIL bp_held: got v=%b %h want 1/%h", ov0, oa0, val[7:0]); end
    n_cmp++; if (oidx0 !== 3'd7) begin n_bad++; $display("FAIL bp_idx: got %0d want 7", oidx0); end
    step(0, 1, int'(val[15]), 0, 0);
    n_cmp++; if (sr[0] !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready: got %b want 0", sr[0]); end
    n_cmp++; if (oidx0 !== 3'd7 || oa0 !== val[7:0]) begin n_bad++; $display("FAIL bp_stall: got idx=%0d %h want 7/%h", oidx0, oa0, val[7:0]); end
    step(0, 1, int'(val[15]), 0, 1);
    n_cmp++; if (sr[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", sr[0]); end
    n_cmp++; if (ov0 !== 1'b1 || oa0 !== val[15:8] || oidx0 !== 3'd0) begin n_bad++; $display("FAIL bp_word2: got v=%b %h idx=%0d want 1/%h/0", ov0, oa0, oidx0, val[15:8]); end
    step(0, 0, 0, 0, 1);
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", ov0); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 1);
    n_cmp++; if (oidx0 !== 3'd3) begin n_bad++; $display("FAIL flush_pre_idx: got %0d want 3", oidx0); end
    step(0, 1, 1, 1, 1);
    n_cmp++; if (oidx0 !== 3'd0 || ov0 !== 1'b0) begin n_bad++; $display("FAIL flush_idx: got idx=%0d v=%b want 0/0", oidx0, ov0); end
    for (int k = 0; k < 8; k++) step(0, 1, 1, 0, 0);
    n_cmp++; if (ov0 !== 1'b1 || oa0 !== 8'hFF) begin n_bad++; $display("FAIL flush_word: got v=%b %h want 1/ff", ov0, oa0); end
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    n_cmp++; if (ov0 !== 1'b1 || oa0 !== 8'hFF || oidx0 !== 3'd0) begin n_bad++; $display("FAIL flush_keeps_word: got v=%b %h idx=%0d want 1/ff/0", ov0, oa0, oidx0); end
    step(0, 0, 0, 0, 1);
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL flush_drain: got %b want 0", ov0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] val;
    for (int k = 0; k < 13; k++) step(0, 1, $urandom_range(0, 1), 0, 0);
    n_cmp++; if (ov0 !== 1'b1 || oidx0 !== 3'd5) begin n_bad++; $display("FAIL rmid_pre: got v=%b idx=%0d want 1/5", ov0, oidx0); end
    rst = 1'b1;
    step(0, 1, 1, 1, 0);
    rst = 1'b0;
    n_cmp++; if (ov0 !== 1'b0 || oidx0 !== 3'd0 || oa0 !== 8'h00) begin n_bad++; $display("FAIL rmid_clear: got v=%b idx=%0d %h want 0/0/00", ov0, oidx0, oa0); end
    val = 8'($urandom);
    for (int k = 0; k < 8; k++) step(0, 1, int'(val[k]), 0, 1);
    n_cmp++; if (ov0 !== 1'b1 || oa0 !== val) begin n_bad++; $display("FAIL rmid_word: got v=%b %h want 1/%h", ov0, oa0, val); end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic       gv[2], gr[2];
    logic [7:0] ga[2];
    int         gi[2];
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        tv[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        ta[k] = int'($urandom_range(0, 15));
        tf[k] = ($urandom_range(0, 15) == 0) ? 1 : 0;
        tr[k] = ($urandom_range(0, 2) != 0) ? 1 : 0;
      end
      tick();
      gv[0] = ov0; ga[0] = oa0; gi[0] = int'(oidx0); gr[0] = sr[0];
      gv[1] = ov1; ga[1] = oa1; gi[1] = int'(oidx1); gr[1] = sr[1];
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (gr[k] !== er[k]) begin n_bad++; $display("FAIL rnd_ready dut%0d cyc%0d: got %b want %b", k, n, gr[k], er[k]); end
        n_cmp++; if (gv[k] !== mv[k]) begin n_bad++; $display("FAIL rnd_valid dut%0d cyc%0d: got %b want %b", k, n, gv[k], mv[k]); end
        n_cmp++; if (ga[k] !== mw[k]) begin n_bad++; $display("FAIL rnd_data dut%0d cyc%0d: got %h want %h", k, n, ga[k], mw[k]); end
        n_cmp++; if (gi[k] != mc[k]) begin n_bad++; $display("FAIL rnd_idx dut%0d cyc%0d: got %0d want %0d", k, n, gi[k], mc[k]); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0; mp[k] = '0; mw[k] = '0; mv[k] = 1'b0;
      er[k] = 1'b1; sr[k] = 1'b1;
      tv[k] = 0; ta[k] = 0; tf[k] = 0; tr[k] = 1;
    end
    test_reset();
    test_lsb_first();
    test_msb_lane4();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
